// File: rtl/mips_fetch_pkg.sv
// rtl/mips_fetch_pkg.sv - shared constants and entry type for the instruction fetch front end
package mips_fetch_pkg;

    localparam int unsigned PC_INC       = 4;
    localparam int unsigned FETCH_ADDR_W = 32;
    localparam int unsigned FETCH_DATA_W = 32;

    typedef struct packed {
        logic [FETCH_ADDR_W-1:0] pc;
        logic [FETCH_DATA_W-1:0] instr;
    } fetch_entry_t;

    // Counter width able to hold 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - prefetch queue storage with occupancy count and single-cycle flush
module fetch_fifo
    import mips_fetch_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PW   = $clog2(DEPTH),
    localparam int unsigned CW   = cnt_width(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             valid_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    assign valid_o = (count_q != '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rptr_q];

    // Flush wins over push and pop: a redirect voids both in the same cycle.
    always_comb begin
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        if (flush_i) begin
            rptr_d  = '0;
            wptr_d  = '0;
            count_d = '0;
        end else begin
            if (push_i) begin
                wptr_d = wptr_q + PW'(1);
            end
            if (do_pop) begin
                rptr_d = rptr_q + PW'(1);
            end
            case ({push_i, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
            if (push_i && !flush_i) begin
                mem_q[wptr_q] <= wdata_i;
            end
        end
    end

endmodule

// File: rtl/instr_fetch_queue.sv
// rtl/instr_fetch_queue.sv - PC generator, in-flight tracking and issue credit around the prefetch queue
module instr_fetch_queue
    import mips_fetch_pkg::*;
#(
    parameter int unsigned        ADDR_W   = 32,
    parameter int unsigned        DATA_W   = 32,
    parameter int unsigned        DEPTH    = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr_data,
    output logic [ADDR_W-1:0] instr_pc
);

    localparam int unsigned CW = cnt_width(DEPTH);
    localparam int unsigned EW = ADDR_W + DATA_W;

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
    logic              inflight_q, inflight_d;
    logic              kill_q, kill_d;

    logic [CW-1:0]     count;
    logic [CW:0]       occupancy;
    logic [EW-1:0]     head;
    logic              pop;
    logic              push;

    assign pop       = instr_valid && instr_ready;
    assign push      = inflight_q && !kill_q;
    assign imem_addr = fetch_pc_q;

    // Credit counts the outstanding response, so a landing push always has room.
    assign occupancy = {1'b0, count} + (CW+1)'(inflight_q) - (CW+1)'(pop);
    assign imem_req  = !reset && !redirect_valid && (occupancy < (CW+1)'(DEPTH));

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = imem_req;
        inflight_pc_d = fetch_pc_q;
        kill_d        = redirect_valid && inflight_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & ~ADDR_W'(PC_INC - 1);
        end else if (imem_req) begin
            fetch_pc_d = fetch_pc_q + ADDR_W'(PC_INC);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            inflight_pc_q <= '0;
            inflight_q    <= 1'b0;
            kill_q        <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_pc_q <= inflight_pc_d;
            inflight_q    <= inflight_d;
            kill_q        <= kill_d;
        end
    end

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clock),
        .rst_i   (reset),
        .flush_i (redirect_valid),
        .push_i  (push),
        .wdata_i ({inflight_pc_q, imem_rdata}),
        .pop_i   (pop),
        .rdata_o (head),
        .valid_o (instr_valid),
        .count_o (count)
    );

    assign instr_pc   = head[EW-1:DATA_W];
    assign instr_data = head[DATA_W-1:0];

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb/tb_instr_fetch_queue.sv - randomized and directed checks of instr_fetch_queue against a queue model
module tb_instr_fetch_queue;
    import mips_fetch_pkg::*;

    localparam int          DEPTH   = 4;
    localparam logic [31:0] RST_PC  = 32'hFFFF_FFF8;
    localparam logic [31:0] XOR_KEY = 32'hA5A5_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;

    always #5 clock = ~clock;

    instr_fetch_queue #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .DEPTH    (DEPTH),
        .RESET_PC (RST_PC)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference: the list of entries decode should see, plus the one outstanding fetch.
    fetch_entry_t exp_q[$];
    logic [31:0]  m_fetch_pc;
    bit           m_pend;
    logic [31:0]  m_pend_pc;

    bit          obs_req, obs_valid;
    logic [31:0] obs_addr, obs_pc, obs_data;

    task automatic model_reset();
        exp_q.delete();
        m_fetch_pc = RST_PC;
        m_pend     = 1'b0;
        m_pend_pc  = '0;
    endtask

    task automatic run_cycle(input bit rv, input logic [31:0] rpc, input bit rdy);
        bit           m_valid, m_pop, m_req;
        int           occ;
        fetch_entry_t e;
        redirect_valid = rv;
        redirect_pc    = rpc;
        instr_ready    = rdy;
        imem_rdata     = m_pend ? (m_pend_pc ^ XOR_KEY) : $urandom();
        @(negedge clock);
        m_valid = (exp_q.size() != 0);
        m_pop   = m_valid && rdy;
        occ     = exp_q.size() + int'(m_pend) - int'(m_pop);
        m_req   = !rv && (occ < DEPTH);
        obs_req   = imem_req;
        obs_addr  = imem_addr;
        obs_valid = instr_valid;
        obs_pc    = instr_pc;
        obs_data  = instr_data;
        check("instr_valid", 32'(instr_valid), 32'(m_valid));
        if (m_valid) begin
            check("instr_pc", instr_pc, exp_q[0].pc);
            check("instr_data", instr_data, exp_q[0].instr);
        end
        check("imem_req", 32'(imem_req), 32'(m_req));
        if (m_req) begin
            check("imem_addr", imem_addr, m_fetch_pc);
        end
        if (rv) begin
            exp_q.delete();
            m_pend     = 1'b0;
            m_fetch_pc = rpc & ~32'd3;
        end else begin
            if (m_pop) void'(exp_q.pop_front());
            if (m_pend) begin
                e.pc    = m_pend_pc;
                e.instr = m_pend_pc ^ XOR_KEY;
                exp_q.push_back(e);
            end
            m_pend    = m_req;
            m_pend_pc = m_fetch_pc;
            if (m_req) m_fetch_pc = m_fetch_pc + 32'd4;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_addr", imem_addr, RST_PC);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_data", instr_data, 32'd0);
        check("rst_pc", instr_pc, 32'd0);
        repeat (2) @(posedge clock);
        #1;
        redirect_valid = 1'b0;
        instr_ready    = 1'b0;
        reset          = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [31:0] heads[$];
        logic [31:0] wrap_exp[4];
        int          first_valid;
        int          reqs;
        int          bias;

        model_reset();
        @(posedge clock);
        #1;
        do_reset();

        // Free-run from reset across the 32-bit PC wrap.
        wrap_exp[0] = 32'hFFFF_FFF8;
        wrap_exp[1] = 32'hFFFF_FFFC;
        wrap_exp[2] = 32'h0000_0000;
        wrap_exp[3] = 32'h0000_0004;
        first_valid = -1;
        for (int c = 0; c < 8; c++) begin
            run_cycle(1'b0, '0, 1'b1);
            if (c == 0) begin
                check("c0_req", 32'(obs_req), 32'd1);
                check("c0_addr", obs_addr, RST_PC);
            end
            if (obs_valid) begin
                heads.push_back(obs_pc);
                if (first_valid < 0) first_valid = c;
            end
        end
        check("first_head_cycle", 32'(first_valid), 32'd2);
        for (int i = 0; i < 4; i++) begin
            check("wrap_head", (i < heads.size()) ? heads[i] : 32'hDEAD_BEEF, wrap_exp[i]);
        end

        // Free-run from a redirect target.
        run_cycle(1'b1, 32'h0040_0000, 1'b1);
        for (int c = 1; c <= 12; c++) begin
            run_cycle(1'b0, '0, 1'b1);
            if (c >= 3) begin
                check("run_valid", 32'(obs_valid), 32'd1);
                check("run_pc", obs_pc, 32'h0040_0000 + 32'(4 * (c - 3)));
                check("run_data", obs_data, (32'h0040_0000 + 32'(4 * (c - 3))) ^ XOR_KEY);
            end
        end

        // Backpressure: exactly DEPTH requests, resume on first pop.
        run_cycle(1'b1, 32'h0000_2000, 1'b0);
        reqs = 0;
        for (int c = 0; c < 10; c++) begin
            run_cycle(1'b0, '0, 1'b0);
            reqs += int'(obs_req);
        end
        check("bp_reqs", 32'(reqs), 32'(DEPTH));
        run_cycle(1'b0, '0, 1'b1);
        check("bp_resume_req", 32'(obs_req), 32'd1);
        check("bp_resume_addr", obs_addr, 32'h0000_2010);
        check("bp_head", obs_pc, 32'h0000_2000);
        for (int c = 0; c < 10; c++) run_cycle(1'b0, '0, 1'b1);

        // Redirect while the fetch of 0x10 is in flight.
        run_cycle(1'b1, 32'h0000_0010, 1'b1);
        run_cycle(1'b0, '0, 1'b1);
        check("rif_req", 32'(obs_req), 32'd1);
        check("rif_addr", obs_addr, 32'h0000_0010);
        run_cycle(1'b1, 32'h0000_1003, 1'b1);
        run_cycle(1'b0, '0, 1'b1);
        check("rif_r1_valid", 32'(obs_valid), 32'd0);
        check("rif_r1_req", 32'(obs_req), 32'd1);
        check("rif_r1_addr", obs_addr, 32'h0000_1000);
        run_cycle(1'b0, '0, 1'b1);
        run_cycle(1'b0, '0, 1'b1);
        check("rif_r3_valid", 32'(obs_valid), 32'd1);
        check("rif_r3_pc", obs_pc, 32'h0000_1000);

        // Redirect in the same cycle as a pop.
        run_cycle(1'b1, 32'h0000_7000, 1'b0);
        repeat (4) run_cycle(1'b0, '0, 1'b0);
        run_cycle(1'b1, 32'h0000_3000, 1'b1);
        check("sim_pre_valid", 32'(obs_valid), 32'd1);
        run_cycle(1'b0, '0, 1'b1);
        check("sim_r1_valid", 32'(obs_valid), 32'd0);
        run_cycle(1'b0, '0, 1'b1);
        check("sim_r2_valid", 32'(obs_valid), 32'd0);
        run_cycle(1'b0, '0, 1'b1);
        check("sim_r3_pc", obs_pc, 32'h0000_3000);
        check("sim_r3_data", obs_data, 32'h0000_3000 ^ XOR_KEY);

        // Asynchronous reset with three entries queued.
        run_cycle(1'b1, 32'h0000_5000, 1'b0);
        for (int c = 0; c < 10 && exp_q.size() != 3; c++) run_cycle(1'b0, '0, 1'b0);
        check("ar_pre_valid", 32'(instr_valid), 32'd1);
        do_reset();
        run_cycle(1'b0, '0, 1'b1);
        check("ar_c0_req", 32'(obs_req), 32'd1);
        check("ar_c0_addr", obs_addr, RST_PC);
        run_cycle(1'b0, '0, 1'b1);
        run_cycle(1'b0, '0, 1'b1);
        check("ar_c2_pc", obs_pc, RST_PC);

        // Random traffic with varying consumer pressure and redirects.
        bias = 7;
        for (int c = 0; c < 1500; c++) begin
            if (c % 100 == 0) bias = $urandom_range(0, 10);
            run_cycle($urandom_range(0, 15) == 0, $urandom(), $urandom_range(0, 9) < bias);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch_queue.md
# instr_fetch_queue

Parametrised instruction-fetch front end for the MIPS core. It replaces the bare PC register and PC+4 adder pair with a PC generator and a prefetch queue of `DEPTH` entries. It issues sequential word fetches to a fixed-latency instruction memory and buffers `{pc, instr}` pairs for the decode stage behind a valid/ready handshake. A branch or jump redirect flushes the queue, squashes any in-flight fetch and restarts fetching at the target.

## Interface
- `ADDR_W`, default 32: PC and memory address width.
- `DATA_W`, default 32: instruction width.
- `DEPTH`, default 4: queue entries. Must be at least 2 and a power of two.
- `RESET_PC`, default 0: first fetch address. Low 2 bits must be 0.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `imem_req` out 1: fetch request this cycle.
- `imem_addr` out ADDR_W: fetch address. Word aligned.
- `imem_rdata` in DATA_W: instruction word. Valid exactly one cycle after the matching `imem_req`.
- `redirect_valid` in 1: branch/jump taken. Takes priority over everything else.
- `redirect_pc` in ADDR_W: new fetch target. Bits [1:0] are ignored and forced to 0.
- `instr_valid` out 1: queue head is valid.
- `instr_ready` in 1: decode accepts the head.
- `instr_data` out DATA_W: head instruction.
- `instr_pc` out ADDR_W: head PC. Decode derives PC+4 for branch targets from this value.

## Operation
- State:
  - `fetch_pc`.
  - Queue storage, read pointer, write pointer and `count` (0..DEPTH).
  - `inflight`: one bit, request issued last cycle.
  - `inflight_pc`.
  - `kill`: one bit, squash the in-flight response.
- Issue:
  - Condition: `imem_req = !redirect_valid && (count + inflight - pop) < DEPTH`, where `pop = instr_valid && instr_ready`.
  - On issue: `imem_addr = fetch_pc`, then `fetch_pc <= fetch_pc + 4`. The PC wraps modulo 2^ADDR_W with no error.
- Response:
  - If `inflight && !kill`, push `{inflight_pc, imem_rdata}` at the write pointer.
  - If `kill` is set, the response is discarded.
- Pop: on `instr_valid && instr_ready` the read pointer advances.
- Push and pop in the same cycle leave `count` unchanged.
- Credit rule: `count + inflight <= DEPTH` always holds, so a push can never overflow the queue.
- Redirect (`redirect_valid = 1`):
  - `count`, read pointer and write pointer are cleared.
  - `fetch_pc <= {redirect_pc[ADDR_W-1:2], 2'b00}`.
  - `kill <= inflight`.
  - No issue in the redirect cycle. A pop in the same cycle is void: the consumer must treat the head as flushed.
  - A redirect on consecutive cycles keeps the last target.
- `kill` clears on the cycle after it has suppressed one response.
- Pointers wrap at DEPTH. Full is `count == DEPTH`; empty is `count == 0`.

## Timing
- Reset values:
  - `imem_req = 0`, `imem_addr = RESET_PC`.
  - `instr_valid = 0`, `instr_data = 0`, `instr_pc = 0`.
  - `fetch_pc = RESET_PC`; `count`, `inflight` and `kill` all 0.
- Reset asserted mid-operation clears all state immediately, with no clock required.
- First cycle after reset deassertion (cycle 0): `imem_req = 1`, `imem_addr = RESET_PC`.
- Response lands in cycle 1 and is written at the end of cycle 1. `instr_valid = 1` with `instr_pc = RESET_PC` in cycle 2.
- Request-to-head latency is 2 cycles.
- Redirect in cycle R: first request to the target in cycle R+1. The target is at the head in cycle R+3.
- Throughput: with `instr_ready` held high, one instruction per cycle is sustained from cycle 2.
- Stalled consumer: the queue fills to DEPTH and `imem_req` drops. It reasserts in the same cycle as the first pop, because the issue condition includes `pop`.
- `instr_data` and `instr_pc` are driven straight from storage, with no combinational path from `imem_rdata`.

## Structure
- Package `mips_fetch_pkg`:
  - `PC_INC = 4`.
  - Typedef `fetch_entry_t` (`pc`, `instr`), parametrised through package parameters that match the defaults.
- Sub-module `fetch_fifo`: synchronous FIFO with storage, pointers, `count`, push/pop, and a `flush` input.
- `instr_fetch_queue` holds the PC generator, the `inflight`/`kill` tracking and the issue logic.

## Test plan
- **Reset then free-run.** Stimulus: `RESET_PC = 0x0040_0000`, `instr_ready = 1`, memory returns `addr ^ 0xA5A5_0000`. Required: `instr_pc` runs 0x0040_0000, 0x0040_0004, … one per cycle from cycle 2, and each `instr_data` matches.
- **Backpressure.** Stimulus: `DEPTH = 4`, `instr_ready = 0` for 10 cycles, then 1. Required: exactly 4 requests are issued and `count` peaks at 4 with no lost or duplicated PC. `imem_req` reasserts in the first pop cycle, and the head sequence is continuous.
- **Redirect with a fetch in flight.** Stimulus: `redirect_valid` with `redirect_pc = 0x0000_1003` one cycle after a request to 0x0000_0010. Required: the response for 0x10 is dropped, the queue is empty in cycle R+1, the first request goes to 0x0000_1000, and the head `instr_pc = 0x0000_1000` in cycle R+3.
- **PC wrap.** Stimulus: `ADDR_W = 32`, `RESET_PC = 0xFFFF_FFF8`. Required: head PCs are 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000, 0x0000_0004.
- **Async reset mid-run.** Stimulus: assert `reset` between clock edges while `count = 3`. Required: `instr_valid` and `imem_req` go to 0 immediately, and after release the fetch restarts at `RESET_PC`.
- **Simultaneous redirect and pop.** Stimulus: `instr_valid = instr_ready = redirect_valid = 1` in the same cycle. Required: the queue is flushed, there is no stale head afterwards, and the next head is the redirect target.
